// File: rtl/iobus_initiator.sv
// iobus_initiator: drives the OTTER IOBUS from a command/response handshake,
// standing in for the MCU during bring-up.
// Optional feature: define IOBUS_INIT_RDBACK_EN to read each write back at
// the same address and flag a mismatch on rsp_err.
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; the source holds valid and its payload until then.
module iobus_initiator #(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             s_reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_wr,
   input  logic [31:0]      cmd_addr,
   input  logic [31:0]      cmd_wdata,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_rdata,
   output logic             rsp_err,
   output logic [31:0]      IOBUS_ADDR,
   output logic [31:0]      IOBUS_OUT,
   output logic             IOBUS_WR,
   input  logic [31:0]      IOBUS_IN,
   output logic             busy,
   output logic [CNT_W-1:0] txn_count,
   output logic [2:0]       state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_WRITE  = 3'd2,
      S_WAIT   = 3'd3,
      S_SAMPLE = 3'd4,
      S_RESP   = 3'd5
   } state_t;

   // WAIT lasts WAIT_CYCLES cycles: counter starts at WAIT_CYCLES-1 and the
   // state exits when it reads zero.
   localparam bit         HAS_WAIT  = (WAIT_CYCLES != 0);
   localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

   state_t     state;
   state_t     state_nx;
   logic       wr_q;
   logic [3:0] wait_cnt;
   logic       accept;
   logic       rsp_hs;

   assign accept    = (state == S_IDLE) && cmd_valid && cmd_ready;
   assign rsp_hs    = (state == S_RESP) && rsp_valid && rsp_ready;
   assign state_dbg = state;

   // State register.
   always_ff @(posedge clk) begin
      if (s_reset) state <= S_IDLE;
      else         state <= state_nx;
   end

   // Next-state decode.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (accept) state_nx = S_SETUP;
         S_SETUP: begin
            if (wr_q)          state_nx = S_WRITE;
            else if (HAS_WAIT) state_nx = S_WAIT;
            else               state_nx = S_SAMPLE;
         end
`ifdef IOBUS_INIT_RDBACK_EN
         S_WRITE:  state_nx = HAS_WAIT ? S_WAIT : S_SAMPLE;
`else
         S_WRITE:  state_nx = S_RESP;
`endif
         S_WAIT:   if (wait_cnt == 4'd0) state_nx = S_SAMPLE;
         S_SAMPLE: state_nx = S_RESP;
         S_RESP:   if (rsp_hs) state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   // Registered outputs and datapath; strobes are decoded from the next
   // state so they line up exactly with the state they belong to.
   always_ff @(posedge clk) begin
      if (s_reset) begin
         cmd_ready  <= 1'b0;
         busy       <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= 32'd0;
         rsp_err    <= 1'b0;
         IOBUS_ADDR <= 32'd0;
         IOBUS_OUT  <= 32'd0;
         IOBUS_WR   <= 1'b0;
         txn_count  <= '0;
         wr_q       <= 1'b0;
         wait_cnt   <= 4'd0;
      end else begin
         cmd_ready <= (state_nx == S_IDLE);
         busy      <= (state_nx != S_IDLE);
         rsp_valid <= (state_nx == S_RESP);
         IOBUS_WR  <= (state_nx == S_WRITE);
         if (accept) begin
            wr_q       <= cmd_wr;
            IOBUS_ADDR <= cmd_addr;
            IOBUS_OUT  <= cmd_wdata;
            rsp_rdata  <= 32'd0;
            rsp_err    <= 1'b0;
         end
         if (state == S_WAIT)            wait_cnt <= wait_cnt - 4'd1;
         else if (state_nx == S_WAIT)    wait_cnt <= WAIT_LOAD;
         if (state == S_SAMPLE) begin
            rsp_rdata <= IOBUS_IN;
`ifdef IOBUS_INIT_RDBACK_EN
            rsp_err   <= wr_q && (IOBUS_IN != IOBUS_OUT);
`else
            rsp_err   <= 1'b0;
`endif
         end
         if (rsp_hs) txn_count <= txn_count + CNT_W'(1);
      end
   end

endmodule
